axil_slave_write_ctrl: RTL and testbench

// - AXI4-Lite slave write-path controller. Sits directly downstream of the

---
 rtl/axil_slave_write_ctrl.sv | 156 +++++++++++++++
 tb/tb_axil_slave_write_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_slave_write_ctrl.sv
// AXI4-Lite slave write-path controller: pairs one AW with one W, strobes a register file, returns B.
// Latency: last AW/W handshake in cycle N -> reg_wr_en in N+1 -> BVALID in N+2 (one write per 3 cycles).
// Backpressure: one write outstanding; AWREADY/WREADY stay low until the B handshake, BREADY low holds RESP.
// Optional feature macro: AXIL_ADDR_CHECK_EN (misaligned / out-of-range writes are dropped with SLVERR).
module axil_slave_write_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    localparam int STRB_W  = DATA_W / 8,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [2:0]        AWPROT,
    input  logic              WVALID,
    output logic              WREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [STRB_W-1:0] WSTRB,
    output logic              BVALID,
    input  logic              BREADY,
    output logic [1:0]        BRESP,
    output logic              reg_wr_en,
    output logic [IDX_W-1:0]  reg_idx,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [STRB_W-1:0] reg_wstrb,
    output logic [2:0]        reg_prot
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               aw_got_q, aw_got_d;
    logic               w_got_q, w_got_d;
    logic               awready_q, awready_d;
    logic               wready_q, wready_d;
    logic               bvalid_q, bvalid_d;
    logic [1:0]         bresp_q, bresp_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [2:0]         prot_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [STRB_W-1:0]  wstrb_q;
    logic               aw_hs, w_hs, b_hs;
    logic               access_legal;

    assign aw_hs = AWVALID & awready_q;
    assign w_hs  = WVALID & wready_q;
    assign b_hs  = bvalid_q & BREADY;

`ifdef AXIL_ADDR_CHECK_EN
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);

    // Only word-aligned addresses inside the register window reach the register file.
    assign access_legal = (addr_q[1:0] == 2'b00) && (addr_q < ADDR_LIMIT);
`else
    // Without checking the index simply wraps; the byte offset and upper bits are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_q[ADDR_W-1:IDX_W+2], addr_q[1:0]};
    assign access_legal     = 1'b1;
`endif

    // Next-state logic: collect both channels, write once, then hold the response.
    always_comb begin
        state_d  = state_q;
        aw_got_d = aw_got_q | aw_hs;
        w_got_d  = w_got_q | w_hs;
        bresp_d  = bresp_q;
        unique case (state_q)
            ST_IDLE: begin
                if (aw_got_d && w_got_d) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = ST_RESP;
                bresp_d = access_legal ? RESP_OKAY : RESP_SLVERR;
            end
            ST_RESP: begin
                if (b_hs) begin
                    state_d  = ST_IDLE;
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                aw_got_d = 1'b0;
                w_got_d  = 1'b0;
            end
        endcase
        // Ready/valid are registered from the next state so they never depend on inputs combinationally.
        awready_d = (state_d == ST_IDLE) && !aw_got_d;
        wready_d  = (state_d == ST_IDLE) && !w_got_d;
        bvalid_d  = (state_d == ST_RESP);
    end

    // Control state and registered handshake outputs.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= ST_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Payload capture on each channel's handshake; values persist until the next write.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            addr_q  <= '0;
            prot_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            if (aw_hs) begin
                addr_q <= AWADDR;
                prot_q <= AWPROT;
            end
            if (w_hs) begin
                wdata_q <= WDATA;
                wstrb_q <= WSTRB;
            end
        end
    end

    assign AWREADY   = awready_q;
    assign WREADY    = wready_q;
    assign BVALID    = bvalid_q;
    assign BRESP     = bresp_q;
    assign reg_wr_en = (state_q == ST_WRITE) && access_legal;
    assign reg_idx   = addr_q[IDX_W+1:2];
    assign reg_wdata = wdata_q;
    assign reg_wstrb = wstrb_q;
    assign reg_prot  = prot_q;

endmodule

// File: tb/tb_axil_slave_write_ctrl.sv
// Directed bench for axil_slave_write_ctrl (NUM_REGS=16, DATA_W=32).
// Inputs are driven and outputs sampled on the falling edge; handshakes happen on the rising edge.
// Expected values are hand-derived from the write-path timing (reg_wr_en at N+1, BVALID at N+2).
module tb_axil_slave_write_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        WVALID;
    logic        WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    logic        reg_wr_en;
    logic [3:0]  reg_idx;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic [2:0]  reg_prot;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 ACLK = ~ACLK;

    axil_slave_write_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(16)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .reg_wr_en(reg_wr_en), .reg_idx(reg_idx), .reg_wdata(reg_wdata),
        .reg_wstrb(reg_wstrb), .reg_prot(reg_prot)
    );

    task automatic test_reset();
        ARESETn = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        AWADDR = '0; AWPROT = '0; WDATA = '0; WSTRB = '0;
        repeat (3) @(negedge ACLK);
        n_checks++;
        if ({AWREADY, WREADY, BVALID, BRESP, reg_wr_en, reg_idx, reg_wdata, reg_wstrb, reg_prot} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b%b bv=%b br=%b we=%b idx=%h d=%h s=%h p=%h, required all zero",
                     AWREADY, WREADY, BVALID, BRESP, reg_wr_en, reg_idx, reg_wdata, reg_wstrb, reg_prot);
        end
        ARESETn = 1'b1;
        @(negedge ACLK);
        n_checks++;
        if ({AWREADY, WREADY, BVALID} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_release_ready: got aw/w/bv=%b%b%b, required 110", AWREADY, WREADY, BVALID);
        end
    endtask

    // AW and W presented together with BREADY high.
    task automatic test_same_cycle(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                   input logic exp_en, input logic [3:0] exp_idx, input logic [1:0] exp_resp);
        BREADY = 1'b1;
        AWVALID = 1'b1; AWADDR = addr; AWPROT = 3'b101;
        WVALID = 1'b1; WDATA = data; WSTRB = strb;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        n_checks++;
        if ({reg_wr_en, reg_idx, reg_wdata, reg_wstrb, reg_prot} !== {exp_en, exp_idx, data, strb, 3'b101}) begin
            n_fail++;
            $display("FAIL same_cycle_write addr=%h: got we=%b idx=%0d d=%h s=%h p=%b, required we=%b idx=%0d d=%h s=%h p=101",
                     addr, reg_wr_en, reg_idx, reg_wdata, reg_wstrb, reg_prot, exp_en, exp_idx, data, strb);
        end
        n_checks++;
        if ({AWREADY, WREADY, BVALID} !== 3'b000) begin
            n_fail++;
            $display("FAIL same_cycle_write_state addr=%h: got aw/w/bv=%b%b%b, required 000", addr, AWREADY, WREADY, BVALID);
        end
        @(negedge ACLK);
        n_checks++;
        if ({BVALID, BRESP, reg_wr_en} !== {1'b1, exp_resp, 1'b0}) begin
            n_fail++;
            $display("FAIL same_cycle_bresp addr=%h: got bv=%b br=%b we=%b, required bv=1 br=%b we=0",
                     addr, BVALID, BRESP, reg_wr_en, exp_resp);
        end
        @(negedge ACLK);
        n_checks++;
        if ({AWREADY, WREADY, BVALID} !== 3'b110) begin
            n_fail++;
            $display("FAIL same_cycle_return addr=%h: got aw/w/bv=%b%b%b, required 110", addr, AWREADY, WREADY, BVALID);
        end
    endtask

    task automatic test_aw_first();
        BREADY = 1'b1;
        AWVALID = 1'b1; AWADDR = 32'h08; AWPROT = 3'b010;
        @(negedge ACLK);
        AWVALID = 1'b0; AWADDR = 32'h3C;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({AWREADY, WREADY, reg_wr_en, BVALID} !== 4'b0100) begin
                n_fail++;
                $display("FAIL aw_first_wait[%0d]: got aw/w/we/bv=%b%b%b%b, required 0100", i, AWREADY, WREADY, reg_wr_en, BVALID);
            end
            if (i == 2) begin
                WVALID = 1'b1; WDATA = 32'h55; WSTRB = 4'h1;
            end
            @(negedge ACLK);
        end
        WVALID = 1'b0;
        n_checks++;
        if ({reg_wr_en, reg_idx, reg_wdata, reg_wstrb, reg_prot} !== {1'b1, 4'd2, 32'h55, 4'h1, 3'b010}) begin
            n_fail++;
            $display("FAIL aw_first_write: got we=%b idx=%0d d=%h s=%h p=%b, required we=1 idx=2 d=00000055 s=1 p=010",
                     reg_wr_en, reg_idx, reg_wdata, reg_wstrb, reg_prot);
        end
        @(negedge ACLK);
        n_checks++;
        if ({BVALID, BRESP} !== 3'b100) begin
            n_fail++;
            $display("FAIL aw_first_bresp: got bv=%b br=%b, required bv=1 br=00", BVALID, BRESP);
        end
        @(negedge ACLK);
    endtask

    task automatic test_w_first_bready_low();
        BREADY = 1'b0;
        WVALID = 1'b1; WDATA = 32'hCAFE_F00D; WSTRB = 4'hC;
        @(negedge ACLK);
        WVALID = 1'b0;
        n_checks++;
        if ({AWREADY, WREADY, reg_wr_en} !== 3'b100) begin
            n_fail++;
            $display("FAIL w_first_wait: got aw/w/we=%b%b%b, required 100", AWREADY, WREADY, reg_wr_en);
        end
        AWVALID = 1'b1; AWADDR = 32'h2C; AWPROT = 3'b001;
        @(negedge ACLK);
        AWVALID = 1'b0;
        n_checks++;
        if ({reg_wr_en, reg_idx, reg_wdata, reg_wstrb} !== {1'b1, 4'd11, 32'hCAFE_F00D, 4'hC}) begin
            n_fail++;
            $display("FAIL w_first_write: got we=%b idx=%0d d=%h s=%h, required we=1 idx=11 d=cafef00d s=c",
                     reg_wr_en, reg_idx, reg_wdata, reg_wstrb);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            n_checks++;
            if ({BVALID, BRESP, AWREADY, WREADY, reg_wr_en} !== 6'b100000) begin
                n_fail++;
                $display("FAIL w_first_hold[%0d]: got bv=%b br=%b aw=%b w=%b we=%b, required bv=1 br=00 aw=0 w=0 we=0",
                         i, BVALID, BRESP, AWREADY, WREADY, reg_wr_en);
            end
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        n_checks++;
        if ({AWREADY, WREADY, BVALID} !== 3'b110) begin
            n_fail++;
            $display("FAIL w_first_release: got aw/w/bv=%b%b%b, required 110", AWREADY, WREADY, BVALID);
        end
    endtask

    task automatic test_reset_mid_write();
        BREADY = 1'b1;
        AWVALID = 1'b1; AWADDR = 32'h14; AWPROT = 3'b111;
        WVALID = 1'b1; WDATA = 32'h1234_5678; WSTRB = 4'hF;
        @(posedge ACLK);
        #1;
        ARESETn = 1'b0;
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge ACLK);
        n_checks++;
        if ({AWREADY, WREADY, BVALID, BRESP, reg_wr_en, reg_idx, reg_wdata, reg_wstrb, reg_prot} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got rdy=%b%b bv=%b we=%b idx=%h d=%h s=%h p=%h, required all zero",
                     AWREADY, WREADY, BVALID, reg_wr_en, reg_idx, reg_wdata, reg_wstrb, reg_prot);
        end
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        n_checks++;
        if ({AWREADY, WREADY, BVALID, reg_wr_en} !== 4'b1100) begin
            n_fail++;
            $display("FAIL midreset_release: got aw/w/bv/we=%b%b%b%b, required 1100", AWREADY, WREADY, BVALID, reg_wr_en);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            n_checks++;
            if ({BVALID, reg_wr_en} !== 2'b00) begin
                n_fail++;
                $display("FAIL midreset_no_ghost[%0d]: got bv/we=%b%b, required 00", i, BVALID, reg_wr_en);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        logic [3:0]  idxs  [4];
        int wk, hs_n, last;
        addrs[0] = 32'h00; addrs[1] = 32'h1C; addrs[2] = 32'h3C; addrs[3] = 32'h24;
        idxs[0]  = 4'd0;   idxs[1]  = 4'd7;   idxs[2]  = 4'd15;  idxs[3]  = 4'd9;
        wk = 0; hs_n = 0; last = 0;
        BREADY = 1'b1;
        AWADDR = addrs[0]; WDATA = 32'hA000_0000; WSTRB = 4'hF;
        for (int c = 0; c < 13; c++) begin
            if (reg_wr_en) begin
                n_checks++;
                if (wk >= 4 || reg_idx !== idxs[wk] || reg_wdata !== (32'hA000_0000 + 32'(wk))) begin
                    n_fail++;
                    $display("FAIL b2b_write[%0d]: got idx=%0d d=%h, required idx=%0d d=%h",
                             wk, reg_idx, reg_wdata, idxs[wk & 3], 32'hA000_0000 + 32'(wk));
                end
                wk++;
                if (wk < 4) begin
                    AWADDR = addrs[wk]; WDATA = 32'hA000_0000 + 32'(wk);
                end
            end
            AWVALID = (wk < 4); WVALID = (wk < 4);
            if (AWVALID && AWREADY && WREADY) begin
                if (hs_n > 0) begin
                    n_checks++;
                    if (c - last != 3) begin
                        n_fail++;
                        $display("FAIL b2b_spacing[%0d]: got %0d cycles, required 3", hs_n, c - last);
                    end
                end
                last = c;
                hs_n++;
            end
            @(negedge ACLK);
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        n_checks++;
        if (hs_n != 4 || wk != 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d handshakes %0d writes, required 4 and 4", hs_n, wk);
        end
    endtask

    initial begin
        test_reset();
        test_same_cycle(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 4'd4, 2'b00);
        test_aw_first();
        test_w_first_bready_low();
        test_same_cycle(32'h0C, 32'h0BAD_0BAD, 4'h0, 1'b1, 4'd3, 2'b00);
`ifdef AXIL_ADDR_CHECK_EN
        test_same_cycle(32'h40, 32'h1111_2222, 4'hF, 1'b0, 4'd0, 2'b10);
        test_same_cycle(32'h06, 32'h3333_4444, 4'h3, 1'b0, 4'd1, 2'b10);
`else
        test_same_cycle(32'h40, 32'h1111_2222, 4'hF, 1'b1, 4'd0, 2'b00);
        test_same_cycle(32'h06, 32'h3333_4444, 4'h3, 1'b1, 4'd1, 2'b00);
`endif
        test_reset_mid_write();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
